scr1_ahb_ram_responder: RTL and testbench
=========================================

// Module: scr1_ahb_ram_responder
// PURPOSE
//   Synthesizable AHB-Lite slave RAM (responder) for the SCR1 imem/dmem AHB master ports. Used in FPGA
//   builds and as a drop-in replacement for the behavioural bench memory. Supports byte/half/word
//   access, runtime-programmable wait states and a two-cycle ERROR response for illegal transfers.
// PARAMETERS
//   MEM_AW     12   byte-address width of the RAM; size = 2**MEM_AW bytes, word array of 2**(MEM_AW-2)
//   BASE_ADDR  0    responder base address; haddr[31:MEM_AW] must equal BASE_ADDR[31:MEM_AW]
// PORTS
//   clk        in   1   core clock; all logic on posedge
//   rst        in   1   synchronous, active-high reset
//   hsize      in   3   SCR1_HSIZE_8B/16B/32B; any other value is illegal
//   htrans     in   2   SCR1_HTRANS_IDLE/BUSY/NONSEQ/SEQ
//   haddr      in   32  transfer address
//   hwrite     in   1   1 = write transfer
//   hwdata     in   32  write data, valid in the data phase
//   wait_cfg   in   4   wait states inserted before completing each OKAY transfer
//   hready     out  1   transfer done / slave ready
//   hrdata     out  32  read data, valid when hready=1 and hresp=OKAY on a read
//   hresp      out  1   SCR1_HRESP_OKAY (0) / SCR1_HRESP_ERR (1)
// BEHAVIOUR
//   - Reset: hready=1, hresp=OKAY, hrdata=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
//   - Address phase is accepted when hready=1 and htrans is NONSEQ or SEQ. IDLE/BUSY accepted with
//     hready=1 get a zero-wait OKAY with no RAM access.
//   - Accepted transfer is illegal when any of the following holds:
//     hsize > 32B; misaligned (16B with haddr[0]=1, 32B with haddr[1:0]!=0); or base compare fails.
//   - FSM states:
//     IDLE  --legal, wait_cfg=0--> DATA (completes in the next cycle, hready=1)
//     IDLE  --legal, wait_cfg=N>0--> WAIT (hready=0 for N cycles)
//     WAIT  --count reaches 0--> DATA (hready=1)
//     any   --illegal accepted--> ERR1 (hready=0, hresp=ERR) --> ERR2 (hready=1, hresp=ERR)
//     DATA/ERR2 --new accepted transfer--> per the IDLE rules above, else --> IDLE
//   - wait_cfg is sampled once, at address-phase acceptance. Changes mid-transfer do not affect it.
//   - Byte enables come from hsize and haddr[1:0]: 8B gives 1 lane, 16B gives 2 lanes, 32B gives 4 lanes.
//   - Write: hwdata is sampled in the final data-phase cycle (hready=1). Only enabled lanes are committed
//     at that clock edge. No RAM write occurs on ERR.
//   - Read: hrdata carries the full 32-bit word at word address haddr[MEM_AW-1:2], placed in natural
//     lane positions. It holds its value until the next read completes.
//   - Read-after-write: a read whose address phase overlaps the previous write's data phase to the same
//     word returns the merged new data. Forward the enabled lanes of hwdata; no stale bytes.
//   - Back-to-back pipelined transfers with wait_cfg=0 sustain one transfer per cycle.
//   - rst asserted mid-transfer: aborts the transfer. A pending write is not committed. Outputs return to
//     reset values on the next edge.
// STRUCTURE
//   - Shared package: HTRANS/HSIZE/HRESP encodings (existing scr1_ahb.svh), plus a new
//     type_scr1_ahb_rsp_fsm_e enum (IDLE, WAIT, DATA, ERR1, ERR2).
//   - One sub-module, scr1_ahb_ram_bytewr: word-wide RAM with 4 byte write enables and synchronous read.
//   - This top holds the FSM, wait counter, address-phase registers and the forwarding mux.
// TESTING
//   1. Reset, then idle: hready=1, hresp=0, hrdata=0; IDLE transfers complete with OKAY and zero waits.
//   2. wait_cfg=0: NONSEQ write 32B @0x10 = 0xDEADBEEF, then read @0x10 in the next cycle.
//      Expect read data 0xDEADBEEF with hready high every cycle (RAW forwarding).
//   3. Byte write 0xAA @0x13, then half write 0x1234 @0x10, then word read @0x10 -> 0xAA001234
//      (after initialising the word to 0).
//   4. wait_cfg=3: read is held with hready=0 for exactly 3 cycles and completes in the 4th. Changing
//      wait_cfg to 0 mid-wait does not shorten it.
//   5. Word read @0x11, 32B @ out-of-range address, and hsize=3'b011: each gives ERR1 (hready=0, hresp=1)
//      then ERR2 (hready=1, hresp=1). RAM is unchanged afterwards.
//   6. Assert rst during the 2nd wait cycle of a write to 0x20: the word at 0x20 is unchanged, and
//      hready=1, hresp=0 on the cycle after reset.

Source files
------------

// File: rtl/scr1_ahb_ram_responder_pkg.sv
// Shared AHB-Lite encodings and helpers for the SCR1 AHB RAM responder.
package scr1_ahb_ram_responder_pkg;

    localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] SCR1_HSIZE_8B  = 3'b000;
    localparam logic [2:0] SCR1_HSIZE_16B = 3'b001;
    localparam logic [2:0] SCR1_HSIZE_32B = 3'b010;

    localparam logic SCR1_HRESP_OKAY = 1'b0;
    localparam logic SCR1_HRESP_ERR  = 1'b1;

    typedef enum logic [2:0] {
        RspIdle,
        RspWait,
        RspData,
        RspErr1,
        RspErr2
    } type_scr1_ahb_rsp_fsm_e;

    function automatic logic [3:0] scr1_ahb_byte_en(input logic [2:0] hsize,
                                                    input logic [1:0] addr);
        logic [3:0] be;
        case (hsize)
            SCR1_HSIZE_8B:  be = 4'b0001 << addr;
            SCR1_HSIZE_16B: be = addr[1] ? 4'b1100 : 4'b0011;
            default:        be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic scr1_ahb_misaligned(input logic [2:0] hsize,
                                                 input logic [1:0] addr);
        return ((hsize == SCR1_HSIZE_16B) && addr[0])
            || ((hsize == SCR1_HSIZE_32B) && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/scr1_ahb_ram_bytewr.sv
// Word-wide RAM with per-byte write enables and a registered (synchronous) read port.
module scr1_ahb_ram_bytewr #(
    parameter int unsigned WORD_AW = 10
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [3:0]         be_i,
    input  logic [WORD_AW-1:0] waddr_i,
    input  logic [31:0]        wdata_i,
    input  logic               re_i,
    input  logic [WORD_AW-1:0] raddr_i,
    output logic [31:0]        rdata_o
);

    localparam int unsigned Words = 1 << WORD_AW;

    logic [31:0] mem_q [Words];
    logic [31:0] rdata_q;

    // Read returns the pre-write contents when both ports hit the same word.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/scr1_ahb_ram_responder.sv
// AHB-Lite RAM responder: transfer FSM, programmable wait states, ERROR response, RAW forwarding.
module scr1_ahb_ram_responder
    import scr1_ahb_ram_responder_pkg::*;
#(
    parameter int unsigned MEM_AW    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  hsize_i,
    input  logic [1:0]  htrans_i,
    input  logic [31:0] haddr_i,
    input  logic        hwrite_i,
    input  logic [31:0] hwdata_i,
    input  logic [3:0]  wait_cfg_i,
    output logic        hready_o,
    output logic [31:0] hrdata_o,
    output logic        hresp_o
);

    localparam int unsigned WordAw = MEM_AW - 2;

    type_scr1_ahb_rsp_fsm_e st_q, st_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WordAw-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic              write_q, write_d;
    logic [3:0]        fwd_be_q, fwd_be_d;
    logic [31:0]       fwd_data_q, fwd_data_d;
    logic [31:0]       hrdata_q;

    logic [WordAw-1:0] haddr_word;
    logic [31:0]       ram_rdata;
    logic [31:0]       rd_word;
    logic              accept;
    logic              illegal;
    logic              commit_wr;
    logic              ram_re;

    assign haddr_word = haddr_i[MEM_AW-1:2];

    always_comb begin
        hready_o  = (st_q != RspWait) && (st_q != RspErr1);
        hresp_o   = ((st_q == RspErr1) || (st_q == RspErr2)) ? SCR1_HRESP_ERR : SCR1_HRESP_OKAY;
        accept    = hready_o && ((htrans_i == SCR1_HTRANS_NONSEQ) || (htrans_i == SCR1_HTRANS_SEQ));
        illegal   = (hsize_i > SCR1_HSIZE_32B) || scr1_ahb_misaligned(hsize_i, haddr_i[1:0])
                 || (haddr_i[31:MEM_AW] != BASE_ADDR[31:MEM_AW]);
        // A reset in the final data cycle must still drop the pending write.
        commit_wr = (st_q == RspData) && write_q && !rst_i;
        ram_re    = accept && !illegal && !hwrite_i;
    end

    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        be_d       = be_q;
        write_d    = write_q;
        fwd_be_d   = fwd_be_q;
        fwd_data_d = fwd_data_q;

        case (st_q)
            RspWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    st_d = RspData;
                end
            end
            RspErr1: st_d = RspErr2;
            default: st_d = RspIdle;
        endcase

        if (accept) begin
            if (illegal) begin
                st_d = RspErr1;
            end else begin
                addr_d  = haddr_word;
                be_d    = scr1_ahb_byte_en(hsize_i, haddr_i[1:0]);
                write_d = hwrite_i;
                if (wait_cfg_i == 4'd0) begin
                    st_d = RspData;
                end else begin
                    st_d  = RspWait;
                    cnt_d = wait_cfg_i;
                end
            end
        end

        // The RAM read issued here sees pre-write data; remember the lanes being written now.
        if (ram_re) begin
            fwd_be_d   = (commit_wr && (addr_q == haddr_word)) ? be_q : 4'b0000;
            fwd_data_d = hwdata_i;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd_word[8*i +: 8] = fwd_be_q[i] ? fwd_data_q[8*i +: 8] : ram_rdata[8*i +: 8];
        end
        hrdata_o = ((st_q == RspData) && !write_q) ? rd_word : hrdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q       <= RspIdle;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            be_q       <= 4'd0;
            write_q    <= 1'b0;
            fwd_be_q   <= 4'd0;
            fwd_data_q <= 32'd0;
            hrdata_q   <= 32'd0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            write_q    <= write_d;
            fwd_be_q   <= fwd_be_d;
            fwd_data_q <= fwd_data_d;
            hrdata_q   <= hrdata_o;
        end
    end

    scr1_ahb_ram_bytewr #(
        .WORD_AW (WordAw)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (commit_wr),
        .be_i    (be_q),
        .waddr_i (addr_q),
        .wdata_i (hwdata_i),
        .re_i    (ram_re),
        .raddr_i (haddr_word),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_scr1_ahb_ram_responder.sv
// Directed bench for scr1_ahb_ram_responder: inputs driven and outputs sampled on the falling edge.
module tb_scr1_ahb_ram_responder;

    logic        clk;
    logic        rst;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [3:0]  wait_cfg;
    logic        hready;
    logic [31:0] hrdata;
    logic        hresp;

    int total = 0;
    int bad   = 0;

    scr1_ahb_ram_responder #(
        .MEM_AW    (12),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .hsize_i    (hsize),
        .htrans_i   (htrans),
        .haddr_i    (haddr),
        .hwrite_i   (hwrite),
        .hwdata_i   (hwdata),
        .wait_cfg_i (wait_cfg),
        .hready_o   (hready),
        .hrdata_o   (hrdata),
        .hresp_o    (hresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic addr_ph(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                           input logic [31:0] a);
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    task automatic idle();
        addr_ph(2'b00, 1'b0, 3'b010, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        hwdata   = 32'h0;
        wait_cfg = 4'd0;
        step();
        step();
        total++; if (hready !== 1'b1) begin bad++; $display("FAIL reset_hready got=%0b exp=1", hready); end
        total++; if (hresp !== 1'b0) begin bad++; $display("FAIL reset_hresp got=%0b exp=0", hresp); end
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL reset_hrdata got=%h exp=0", hrdata); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr_ph((i == 1) ? 2'b01 : 2'b00, 1'b0, 3'b010, 32'h10);
            step();
            total++;
            if (hready !== 1'b1 || hresp !== 1'b0) begin
                bad++; $display("FAIL idle_okay cyc=%0d got=%0b/%0b exp=1/0", i, hready, hresp);
            end
        end
        idle();
        step();
    endtask

    task automatic test_raw_forward();
        wait_cfg = 4'd0;
        addr_ph(2'b10, 1'b1, 3'b010, 32'h10);
        step();
        total++; if (hready !== 1'b1) begin bad++; $display("FAIL raw_wr_ready got=%0b exp=1", hready); end
        hwdata = 32'hDEADBEEF;
        addr_ph(2'b10, 1'b0, 3'b010, 32'h10);
        step();
        total++; if (hready !== 1'b1) begin bad++; $display("FAIL raw_rd_ready got=%0b exp=1", hready); end
        total++; if (hrdata !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_rd_data got=%h exp=deadbeef", hrdata); end
        idle();
        step();
        total++; if (hrdata !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_hold got=%h exp=deadbeef", hrdata); end
    endtask

    task automatic test_byte_half();
        wait_cfg = 4'd0;
        addr_ph(2'b10, 1'b1, 3'b010, 32'h10);
        step();
        hwdata = 32'h0;
        addr_ph(2'b11, 1'b1, 3'b000, 32'h13);
        step();
        hwdata = 32'hAA555555;
        addr_ph(2'b11, 1'b1, 3'b001, 32'h10);
        step();
        hwdata = 32'hFFFF1234;
        addr_ph(2'b10, 1'b0, 3'b010, 32'h10);
        step();
        total++; if (hready !== 1'b1) begin bad++; $display("FAIL bh_ready got=%0b exp=1", hready); end
        total++; if (hrdata !== 32'hAA001234) begin bad++; $display("FAIL bh_fwd_read got=%h exp=aa001234", hrdata); end
        addr_ph(2'b11, 1'b0, 3'b010, 32'h10);
        step();
        total++; if (hrdata !== 32'hAA001234) begin bad++; $display("FAIL bh_ram_read got=%h exp=aa001234", hrdata); end
        idle();
        step();
    endtask

    task automatic test_wait_states();
        wait_cfg = 4'd0;
        addr_ph(2'b10, 1'b1, 3'b010, 32'h14);
        step();
        hwdata   = 32'h0BADF00D;
        wait_cfg = 4'd3;
        addr_ph(2'b10, 1'b0, 3'b010, 32'h14);
        step();
        total++; if (hrdata !== 32'hAA001234) begin bad++; $display("FAIL ws_hold got=%h exp=aa001234", hrdata); end
        wait_cfg = 4'd0;
        idle();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (hready !== 1'b0) begin bad++; $display("FAIL ws_wait cyc=%0d got=%0b exp=0", i, hready); end
            if (i < 2) step();
        end
        step();
        total++; if (hready !== 1'b1) begin bad++; $display("FAIL ws_done_ready got=%0b exp=1", hready); end
        total++; if (hrdata !== 32'h0BADF00D) begin bad++; $display("FAIL ws_done_data got=%h exp=0badf00d", hrdata); end
        step();
    endtask

    task automatic test_errors();
        logic [1:0]  err_tr [3];
        logic        err_wr [3];
        logic [2:0]  err_sz [3];
        logic [31:0] err_a  [3];
        err_tr = '{2'b10, 2'b10, 2'b11};
        err_wr = '{1'b0, 1'b1, 1'b1};
        err_sz = '{3'b010, 3'b010, 3'b011};
        err_a  = '{32'h11, 32'h1010, 32'h10};
        wait_cfg = 4'd0;
        hwdata   = 32'hFFFFFFFF;
        addr_ph(err_tr[0], err_wr[0], err_sz[0], err_a[0]);
        step();
        for (int i = 0; i < 3; i++) begin
            idle();
            total++;
            if (hready !== 1'b0 || hresp !== 1'b1) begin
                bad++; $display("FAIL err1 case=%0d got=%0b/%0b exp=0/1", i, hready, hresp);
            end
            step();
            total++;
            if (hready !== 1'b1 || hresp !== 1'b1) begin
                bad++; $display("FAIL err2 case=%0d got=%0b/%0b exp=1/1", i, hready, hresp);
            end
            if (i < 2) addr_ph(err_tr[i+1], err_wr[i+1], err_sz[i+1], err_a[i+1]);
            else       addr_ph(2'b10, 1'b0, 3'b010, 32'h10);
            step();
        end
        total++; if (hresp !== 1'b0) begin bad++; $display("FAIL err_after_resp got=%0b exp=0", hresp); end
        total++; if (hrdata !== 32'hAA001234) begin bad++; $display("FAIL err_ram_intact got=%h exp=aa001234", hrdata); end
        idle();
        step();
    endtask

    task automatic test_reset_abort();
        wait_cfg = 4'd2;
        addr_ph(2'b10, 1'b1, 3'b010, 32'h20);
        step();
        hwdata   = 32'hDEAD0000;
        wait_cfg = 4'd0;
        idle();
        total++; if (hready !== 1'b0) begin bad++; $display("FAIL ra_init_wait got=%0b exp=0", hready); end
        step();
        step();
        total++; if (hready !== 1'b1) begin bad++; $display("FAIL ra_init_done got=%0b exp=1", hready); end
        hwdata = 32'h11111111;
        step();
        wait_cfg = 4'd3;
        addr_ph(2'b10, 1'b1, 3'b010, 32'h20);
        step();
        hwdata = 32'h22222222;
        idle();
        step();
        total++; if (hready !== 1'b0) begin bad++; $display("FAIL ra_wait2 got=%0b exp=0", hready); end
        rst = 1'b1;
        step();
        total++;
        if (hready !== 1'b1 || hresp !== 1'b0) begin
            bad++; $display("FAIL ra_post_reset got=%0b/%0b exp=1/0", hready, hresp);
        end
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL ra_post_hrdata got=%h exp=0", hrdata); end
        rst      = 1'b0;
        wait_cfg = 4'd0;
        addr_ph(2'b10, 1'b0, 3'b010, 32'h20);
        step();
        total++; if (hrdata !== 32'h11111111) begin bad++; $display("FAIL ra_word got=%h exp=11111111", hrdata); end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_raw_forward();
        test_byte_half();
        test_wait_states();
        test_errors();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
